// File: rtl/helppll_pkg.sv
// -----------------------------------------------------------------------------
// helppll_pkg
// Shared definitions for the helper-clock PLL loop controller.
//   state_t          : loop state, encoded as seen on the controller's state port
//   ACC_FRAC         : fractional bits carried below the DAC code in the accumulator
//   COARSE_EXIT_CNT  : consecutive in-tolerance strobes needed to leave COARSE
//   sat_add()        : signed add clamped to [0, max_val]
// -----------------------------------------------------------------------------
package helppll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int ACC_FRAC        = 8;
  localparam int COARSE_EXIT_CNT = 2;

  // Operands are carried at 64 bits so that an accumulator of up to ~30 bits
  // plus a shifted 32-bit error can never overflow before the clamp.
  function automatic logic [63:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input logic        [63:0] max_val);
    logic signed [63:0] sum;
    sum = a + b;
    if (sum < 0)
      sat_add = '0;
    else if (sum > $signed(max_val))
      sat_add = max_val;
    else
      sat_add = sum;
  endfunction

endpackage

// File: rtl/helppll_dac_hs.sv
// -----------------------------------------------------------------------------
// helppll_dac_hs
// One-entry, latest-wins valid/ready output register for the tuning DAC.
// A new update always overwrites the held word; nothing is ever queued.
//   clk, resetn : clock, synchronous active-low reset
//   i_flush     : drop any pending word (valid forced low)
//   i_upd       : load i_data and raise valid
//   i_data      : word to present
//   i_ready     : downstream ready
//   o_data      : held word
//   o_valid     : handshake valid
// -----------------------------------------------------------------------------
module helppll_dac_hs import helppll_pkg::*; #(
  parameter int              WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_upd,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of every other register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data  <= RESET_DATA;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_upd) begin
      // If a transfer completes this same cycle, the old word has gone out and
      // the new one is presented with valid still high.
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/helppll_ctrl.sv
// -----------------------------------------------------------------------------
// helppll_ctrl
// Loop controller for the helper-clock PLL (reference-clock domain). Consumes
// frequency-comparator errors, schedules the comparator gate length, runs a
// coarse/fine saturating integrator that drives the tuning DAC, reports lock.
//
// Ports
//   clk, resetn      : reference clock, synchronous active-low reset
//   enable           : run the loop; low forces IDLE and drops pending DAC writes
//   dac_init         : DAC code loaded on each enable rise
//   freqdiff         : signed comparator error (positive = helper fast)
//   stb_freqdiff     : one-cycle qualifier for freqdiff
//   refcntsamp       : comparator gate length
//   dac_data/valid   : tuning DAC word and valid; dac_ready is its ready
//   locked           : loop locked
//   lock_lost        : one-cycle pulse on LOCKED -> COARSE
//   state            : IDLE=0, COARSE=1, FINE=2, LOCKED=3
//   dbacc, dblosscnt : debug accumulator and lock-loss count
//
// Build option: define HELPPLL_CTRL_DBG_EN to drive dbacc/dblosscnt; when it
// is undefined both debug ports read zero and the loss counter is not built.
// Settle and lock counters are 8 bits, so SETTLE and LOCK_CNT must be < 256.
// -----------------------------------------------------------------------------
module helppll_ctrl import helppll_pkg::*; #(
  parameter int DWIDTH      = 32,
  parameter int DACWIDTH    = 16,
  parameter int GATE_COARSE = 1000,
  parameter int GATE_FINE   = 10000,
  parameter int COARSE_GAIN = 4,
  parameter int COARSE_TOL  = 8,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 4,
  parameter int SETTLE      = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [DACWIDTH-1:0]        dac_init,
  input  logic signed [DWIDTH-1:0]   freqdiff,
  input  logic                       stb_freqdiff,
  output logic [DWIDTH-1:0]          refcntsamp,
  output logic [DACWIDTH-1:0]        dac_data,
  output logic                       dac_valid,
  input  logic                       dac_ready,
  output logic                       locked,
  output logic                       lock_lost,
  output logic [1:0]                 state,
  output logic [DACWIDTH+7:0]        dbacc,
  output logic [15:0]                dblosscnt
);

  localparam int              AW        = DACWIDTH + ACC_FRAC;
  localparam logic [63:0]     ACC_MAX   = (64'd1 << AW) - 64'd1;
  localparam logic [AW-1:0]   ACC_RST   = {1'b1, {(AW-1){1'b0}}};
  localparam logic [DWIDTH:0] C_TOL     = (DWIDTH+1)'(COARSE_TOL);
  localparam logic [DWIDTH:0] L_TOL     = (DWIDTH+1)'(LOCK_TOL);
  localparam logic [7:0]      SETTLE_W  = 8'(SETTLE);
  localparam logic [7:0]      LOCK_CNT_W = 8'(LOCK_CNT);
  localparam logic [7:0]      C_EXIT_W  = 8'(COARSE_EXIT_CNT);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_acc, w_acc_nxt;
  logic [7:0]    r_settle, w_settle_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic          r_enable_d;
  logic          r_dac_upd, w_dac_upd_nxt;
  logic          r_lock_lost, w_lock_lost_nxt;

  // |e| at DWIDTH+1 bits so the most negative error negates without overflow.
  logic signed [DWIDTH:0] w_e_wide;
  logic        [DWIDTH:0] w_abs_e;
  logic                   w_in_coarse, w_in_lock;

  assign w_e_wide    = {freqdiff[DWIDTH-1], freqdiff};
  assign w_abs_e     = w_e_wide[DWIDTH] ? -w_e_wide : w_e_wide;
  assign w_in_coarse = (w_abs_e <= C_TOL);
  assign w_in_lock   = (w_abs_e <= L_TOL);

  // Integrator step: COARSE uses the shifted error, FINE/LOCKED the raw error.
  logic signed [63:0] w_fd_ext, w_delta, w_acc64;
  assign w_fd_ext = {{(64-DWIDTH){freqdiff[DWIDTH-1]}}, freqdiff};
  assign w_delta  = (r_state == ST_COARSE) ? -(w_fd_ext <<< COARSE_GAIN) : -w_fd_ext;
  assign w_acc64  = {{(64-AW){1'b0}}, r_acc};

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_settle_nxt    = r_settle;
    w_cnt_nxt       = r_cnt;
    w_dac_upd_nxt   = 1'b0;
    w_lock_lost_nxt = 1'b0;

    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_settle_nxt = '0;
      w_cnt_nxt    = '0;
    end else if (!r_enable_d) begin
      w_acc_nxt     = {dac_init, {ACC_FRAC{1'b0}}};
      w_dac_upd_nxt = 1'b1;
      w_settle_nxt  = SETTLE_W;
      w_cnt_nxt     = '0;
      w_state_nxt   = ST_COARSE;
    end else if (stb_freqdiff && (r_state != ST_IDLE)) begin
      if (r_settle != '0) begin
        w_settle_nxt = r_settle - 8'd1;
      end else begin
        // Accumulator moves with the current state's gain before any transition.
        w_acc_nxt     = AW'(sat_add(w_acc64, w_delta, ACC_MAX));
        w_dac_upd_nxt = 1'b1;
        case (r_state)
          ST_COARSE: begin
            w_cnt_nxt = w_in_coarse ? r_cnt + 8'd1 : '0;
            if (w_cnt_nxt == C_EXIT_W) begin
              w_state_nxt  = ST_FINE;
              w_settle_nxt = SETTLE_W;
              w_cnt_nxt    = '0;
            end
          end
          ST_FINE, ST_LOCKED: begin
            if (!w_in_coarse) begin
              w_state_nxt     = ST_COARSE;
              w_settle_nxt    = SETTLE_W;
              w_cnt_nxt       = '0;
              w_lock_lost_nxt = (r_state == ST_LOCKED);
            end else if (r_state == ST_FINE) begin
              w_cnt_nxt = w_in_lock ? r_cnt + 8'd1 : '0;
              if (w_cnt_nxt == LOCK_CNT_W) begin
                w_state_nxt = ST_LOCKED;
                w_cnt_nxt   = '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: reset is synchronous -- it is just the highest-priority branch under
  // the clock edge, with no reset term in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_acc       <= ACC_RST;
      r_settle    <= '0;
      r_cnt       <= '0;
      r_enable_d  <= 1'b0;
      r_dac_upd   <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_settle    <= w_settle_nxt;
      r_cnt       <= w_cnt_nxt;
      r_enable_d  <= enable;
      r_dac_upd   <= w_dac_upd_nxt;
      r_lock_lost <= w_lock_lost_nxt;
    end
  end

  helppll_dac_hs #(
    .WIDTH      (DACWIDTH),
    .RESET_DATA (ACC_RST[AW-1:ACC_FRAC])
  ) u_dac_hs (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (!enable),
    .i_upd   (r_dac_upd),
    .i_data  (r_acc[AW-1:ACC_FRAC]),
    .i_ready (dac_ready),
    .o_data  (dac_data),
    .o_valid (dac_valid)
  );

  assign refcntsamp = ((r_state == ST_FINE) || (r_state == ST_LOCKED)) ?
                      DWIDTH'(GATE_FINE) : DWIDTH'(GATE_COARSE);
  assign locked     = (r_state == ST_LOCKED);
  assign lock_lost  = r_lock_lost;
  assign state      = r_state;

`ifdef HELPPLL_CTRL_DBG_EN
  logic [15:0] r_loss_cnt;

  always_ff @(posedge clk) begin
    if (!resetn)
      r_loss_cnt <= '0;
    else if (w_lock_lost_nxt && (r_loss_cnt != 16'hFFFF))
      r_loss_cnt <= r_loss_cnt + 16'd1;
  end

  assign dbacc     = r_acc;
  assign dblosscnt = r_loss_cnt;
`else
  assign dbacc     = '0;
  assign dblosscnt = '0;
`endif

endmodule
